// File: rtl/lsu_port_arbiter.sv
// Two-master arbiter for the shared load/store unit port with bounded lock tenures.
// Define LSU_ARB_ROUND_ROBIN_EN for round-robin idle priority; default is fixed m0 > m1.
module lsu_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_m0_req,
    input  logic          i_m0_wren,
    input  logic          i_m0_lock,
    input  logic [AW-1:0] i_m0_addr,
    input  logic [DW-1:0] i_m0_wdata,
    output logic          o_m0_gnt,
    output logic          o_m0_rvalid,
    output logic [DW-1:0] o_m0_rdata,
    input  logic          i_m1_req,
    input  logic          i_m1_wren,
    input  logic          i_m1_lock,
    input  logic [AW-1:0] i_m1_addr,
    input  logic [DW-1:0] i_m1_wdata,
    output logic          o_m1_gnt,
    output logic          o_m1_rvalid,
    output logic [DW-1:0] o_m1_rdata,
    output logic [AW-1:0] o_lsu_addr,
    output logic [DW-1:0] o_st_data,
    output logic          o_lsu_wren,
    input  logic [DW-1:0] i_ld_data
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_lock_cnt;
    logic          r_ovr;
    logic          r_ovr_m1;
    logic          r_m0_rvalid;
    logic          r_m1_rvalid;
    logic [DW-1:0] r_m0_rdata;
    logic [DW-1:0] r_m1_rdata;

    logic          w_def_m1;
    logic          w_pri_m1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_acc_lock;
    logic          w_own_req;
    logic          w_oth_req;
    logic [CW-1:0] w_cnt_inc;
    logic          w_cnt_full;

`ifdef LSU_ARB_ROUND_ROBIN_EN
    logic r_ptr;
    assign w_def_m1 = r_ptr;
`else
    assign w_def_m1 = 1'b0;
`endif

    // A pending starvation override beats whatever the normal idle priority says.
    assign w_pri_m1 = r_ovr ? r_ovr_m1 : w_def_m1;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!i_rst) begin
            case (r_state)
                S_IDLE: begin
                    w_gnt0 = i_m0_req & (~i_m1_req | ~w_pri_m1);
                    w_gnt1 = i_m1_req & (~i_m0_req | w_pri_m1);
                end
                S_OWN0:  w_gnt0 = i_m0_req;
                S_OWN1:  w_gnt1 = i_m1_req;
                default: begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign w_acc_lock = w_gnt1 ? i_m1_lock : i_m0_lock;
    assign w_own_req  = (r_state == S_OWN1) ? i_m1_req : i_m0_req;
    assign w_oth_req  = (r_state == S_OWN1) ? i_m0_req : i_m1_req;
    assign w_cnt_inc  = r_lock_cnt + CW'(1);
    assign w_cnt_full = (w_cnt_inc == CW'(MAX_LOCK));

    assign o_m0_gnt    = w_gnt0;
    assign o_m1_gnt    = w_gnt1;
    assign o_m0_rvalid = r_m0_rvalid;
    assign o_m1_rvalid = r_m1_rvalid;
    assign o_m0_rdata  = r_m0_rdata;
    assign o_m1_rdata  = r_m1_rdata;

    always_comb begin
        o_lsu_addr = '0;
        o_st_data  = '0;
        o_lsu_wren = 1'b0;
        if (w_gnt0) begin
            o_lsu_addr = i_m0_addr;
            o_st_data  = i_m0_wdata;
            o_lsu_wren = i_m0_wren;
        end else if (w_gnt1) begin
            o_lsu_addr = i_m1_addr;
            o_st_data  = i_m1_wdata;
            o_lsu_wren = i_m1_wren;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
        end else begin
            r_m0_rvalid <= w_gnt0 & ~i_m0_wren;
            r_m1_rvalid <= w_gnt1 & ~i_m1_wren;
            if (w_gnt0 && !i_m0_wren) r_m0_rdata <= i_ld_data;
            if (w_gnt1 && !i_m1_wren) r_m1_rdata <= i_ld_data;
        end
    end

    // Tenure tracking; the override only lives for the single idle cycle after a forced exit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_lock_cnt <= '0;
            r_ovr      <= 1'b0;
            r_ovr_m1   <= 1'b0;
`ifdef LSU_ARB_ROUND_ROBIN_EN
            r_ptr      <= 1'b0;
`endif
        end else begin
            r_ovr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        if (w_acc_lock && (MAX_LOCK > 1)) begin
                            r_state    <= w_gnt1 ? S_OWN1 : S_OWN0;
                            r_lock_cnt <= CW'(1);
                        end else begin
`ifdef LSU_ARB_ROUND_ROBIN_EN
                            r_ptr <= ~w_gnt1;
`endif
                        end
                    end
                end
                S_OWN0, S_OWN1: begin
                    if (!w_own_req || !w_acc_lock || w_cnt_full) begin
                        r_state    <= S_IDLE;
                        r_lock_cnt <= '0;
`ifdef LSU_ARB_ROUND_ROBIN_EN
                        r_ptr      <= (r_state == S_OWN0);
`endif
                        if (w_own_req && w_acc_lock && w_cnt_full && w_oth_req) begin
                            r_ovr    <= 1'b1;
                            r_ovr_m1 <= (r_state == S_OWN0);
                        end
                    end else begin
                        r_lock_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Self-checking bench for lsu_port_arbiter: directed literal checks plus a random run
// compared every cycle against a tenure-level model (honours LSU_ARB_ROUND_ROBIN_EN).
module tb_lsu_port_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;
`ifdef LSU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_wren, m0_lock, m1_req, m1_wren, m1_lock;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, ld_data;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, lsu_wren;
    logic [DW-1:0] m0_rdata, m1_rdata, st_data;
    logic [AW-1:0] lsu_addr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_req(m0_req), .i_m0_wren(m0_wren), .i_m0_lock(m0_lock),
        .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
        .o_m0_gnt(m0_gnt), .o_m0_rvalid(m0_rvalid), .o_m0_rdata(m0_rdata),
        .i_m1_req(m1_req), .i_m1_wren(m1_wren), .i_m1_lock(m1_lock),
        .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_lsu_addr(lsu_addr), .o_st_data(st_data), .o_lsu_wren(lsu_wren),
        .i_ld_data(ld_data)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic r,
                                 input logic q0, input logic w0, input logic l0,
                                 input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic q1, input logic w1, input logic l1,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] ld);
        @(posedge clk);
        #1;
        rst = r;
        m0_req = q0; m0_wren = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = q1; m1_wren = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        ld_data = ld;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference model: who owns the port, how many transactions the tenure accepted,
    // idle priority holder and any one-shot starvation override.
    int          m_owner;
    int          m_cnt;
    int          m_ptr;
    int          m_ovr;
    logic        e_rv [2];
    logic [DW-1:0] e_rd [2];

    initial begin
        @(posedge clk);
        m_owner = -1; m_cnt = 0; m_ptr = 0; m_ovr = -1;
        e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
        forever begin
            int            g;
            int            nxt_ovr;
            logic          rq [2];
            logic          wr [2];
            logic          lk [2];
            logic [AW-1:0] ad [2];
            logic [DW-1:0] wd [2];
            @(negedge clk);
            rq[0] = m0_req; rq[1] = m1_req;
            wr[0] = m0_wren; wr[1] = m1_wren;
            lk[0] = m0_lock; lk[1] = m1_lock;
            ad[0] = m0_addr; ad[1] = m1_addr;
            wd[0] = m0_wdata; wd[1] = m1_wdata;

            if (rst) g = -1;
            else if (m_owner >= 0) g = rq[m_owner] ? m_owner : -1;
            else if (rq[0] && rq[1]) g = (m_ovr >= 0) ? m_ovr : (RR ? m_ptr : 0);
            else if (rq[0]) g = 0;
            else if (rq[1]) g = 1;
            else g = -1;

            checkOutput("m_gnt0", m0_gnt, (g == 0));
            checkOutput("m_gnt1", m1_gnt, (g == 1));
            checkOutput("m_addr", lsu_addr, (g >= 0) ? ad[g] : '0);
            checkOutput("m_stdata", st_data, (g >= 0) ? wd[g] : '0);
            checkOutput("m_wren", lsu_wren, (g >= 0) ? wr[g] : 1'b0);
            checkOutput("m_rvalid0", m0_rvalid, e_rv[0]);
            checkOutput("m_rvalid1", m1_rvalid, e_rv[1]);
            checkOutput("m_rdata0", m0_rdata, e_rd[0]);
            checkOutput("m_rdata1", m1_rdata, e_rd[1]);

            if (rst) begin
                m_owner = -1; m_cnt = 0; m_ptr = 0; m_ovr = -1;
                e_rv[0] = 0; e_rv[1] = 0; e_rd[0] = '0; e_rd[1] = '0;
            end else begin
                e_rv[0] = (g == 0) && !wr[0];
                e_rv[1] = (g == 1) && !wr[1];
                if (g >= 0 && !wr[g]) e_rd[g] = ld_data;
                nxt_ovr = -1;
                if (m_owner < 0) begin
                    if (g >= 0) begin
                        if (lk[g] && MAX_LOCK > 1) begin
                            m_owner = g;
                            m_cnt = 1;
                        end else begin
                            m_ptr = 1 - g;
                        end
                    end
                end else if (g < 0) begin
                    m_ptr = 1 - m_owner;
                    m_owner = -1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                    if (!lk[g] || m_cnt == MAX_LOCK) begin
                        if (lk[g] && m_cnt == MAX_LOCK && rq[1 - m_owner]) nxt_ovr = 1 - m_owner;
                        m_ptr = 1 - m_owner;
                        m_owner = -1;
                        m_cnt = 0;
                    end
                end
                m_ovr = nxt_ovr;
            end
        end
    end

    initial begin
        rst = 1;
        m0_req = 0; m0_wren = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_wren = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
        ld_data = '0;

        // Read latency and reset state
        doReset();
        @(negedge clk);
        checkOutput("rst_rvalid0", m0_rvalid, 0);
        checkOutput("rst_rdata1", m1_rdata, 0);
        applyStimulus(0, 1, 0, 0, 32'h7800, 0, 0, 0, 0, 0, 0, 32'h0000_00A5);
        @(negedge clk);
        checkOutput("rd_gnt0", m0_gnt, 1);
        checkOutput("rd_addr", lsu_addr, 32'h7800);
        checkOutput("rd_wren", lsu_wren, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h5A5A_5A5A);
        @(negedge clk);
        checkOutput("rd_rvalid_n1", m0_rvalid, 1);
        checkOutput("rd_rdata_n1", m0_rdata, 32'h0000_00A5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
        @(negedge clk);
        checkOutput("rd_rvalid_n2", m0_rvalid, 0);
        checkOutput("rd_rdata_hold", m0_rdata, 32'h0000_00A5);

        // Contention on writes
        doReset();
        applyStimulus(0, 1, 1, 0, 32'h7000, 32'h1, 1, 1, 0, 32'h2000, 32'h2, 0);
        @(negedge clk);
        checkOutput("ct_gnt0", m0_gnt, 1);
        checkOutput("ct_gnt1", m1_gnt, 0);
        checkOutput("ct_addr", lsu_addr, 32'h7000);
        checkOutput("ct_data", st_data, 32'h1);
        checkOutput("ct_wren", lsu_wren, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h2000, 32'h2, 0);
        @(negedge clk);
        checkOutput("ct2_gnt1", m1_gnt, 1);
        checkOutput("ct2_addr", lsu_addr, 32'h2000);
        checkOutput("ct2_data", st_data, 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("ct_no_wr_rvalid", m1_rvalid, 0);

        // Sustained contention: fixed m0 or alternating
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h100, 0, 1, 0, 0, 32'h200, 0, 32'(i));
            @(negedge clk);
            checkOutput("rr_gnt1", m1_gnt, RR ? (i % 2 == 1) : 1'b0);
            checkOutput("rr_gnt0", m0_gnt, RR ? (i % 2 == 0) : 1'b1);
        end

        // Lock burst of four m1 writes
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h10, 32'hA0, 0);
        @(negedge clk);
        checkOutput("lk_gnt1_0", m1_gnt, 1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h300, 0, 1, 1, (i < 3), 32'h10 + 32'(i), 32'hA0 + 32'(i), 0);
            @(negedge clk);
            checkOutput("lk_gnt1", m1_gnt, 1);
            checkOutput("lk_gnt0", m0_gnt, 0);
        end
        applyStimulus(0, 1, 0, 0, 32'h300, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("lk_gnt0_after", m0_gnt, 1);

        // Starvation cap with m1 as the locker
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h40, 32'h1, 0);
        @(negedge clk);
        checkOutput("sc_gnt1_0", m1_gnt, 1);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 32'h50, 0, 1, 1, 1, 32'h40, 32'h1, 0);
            @(negedge clk);
            checkOutput("sc_gnt1", m1_gnt, 1);
        end
        applyStimulus(0, 1, 0, 0, 32'h50, 0, 1, 1, 1, 32'h40, 32'h1, 0);
        @(negedge clk);
        checkOutput("sc_gnt0_cap", m0_gnt, 1);
        checkOutput("sc_gnt1_cap", m1_gnt, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h40, 32'h1, 0);
        @(negedge clk);
        checkOutput("sc_gnt1_regain", m1_gnt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation cap with m0 as the locker: override beats m0 priority
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 1, 32'h60, 32'h6, 1, 0, 0, 32'h70, 0, 0);
            @(negedge clk);
            checkOutput("sc0_gnt0", m0_gnt, 1);
        end
        applyStimulus(0, 1, 1, 1, 32'h60, 32'h6, 1, 0, 0, 32'h70, 0, 0);
        @(negedge clk);
        checkOutput("sc0_gnt1_cap", m1_gnt, 1);
        checkOutput("sc0_gnt0_cap", m0_gnt, 0);
        applyStimulus(0, 1, 1, 0, 32'h60, 32'h6, 1, 0, 0, 32'h70, 0, 0);
        @(negedge clk);
        checkOutput("sc0_gnt0_next", m0_gnt, 1);

        // Reset in the middle of an m1 lock
        doReset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h44, 0, 32'hBEEF);
        @(negedge clk);
        checkOutput("rm_gnt1", m1_gnt, 1);
        applyStimulus(1, 1, 0, 0, 32'h88, 0, 1, 1, 1, 32'h48, 32'h9, 32'hCAFE);
        @(negedge clk);
        checkOutput("rm_gnt0_rst", m0_gnt, 0);
        checkOutput("rm_gnt1_rst", m1_gnt, 0);
        checkOutput("rm_wren_rst", lsu_wren, 0);
        applyStimulus(0, 1, 0, 0, 32'h88, 0, 1, 1, 1, 32'h48, 32'h9, 32'hCAFE);
        @(negedge clk);
        checkOutput("rm_rvalid1", m1_rvalid, 0);
        checkOutput("rm_rdata1", m1_rdata, 0);
        checkOutput("rm_gnt0_after", m0_gnt, 1);

        // Random traffic checked by the model
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                          $urandom, $urandom,
                          ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                          $urandom, $urandom, $urandom);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
